// File: rtl/seven_seg_digit_driver.sv
// seven_seg_digit_driver
// Takes the scanner's one-cold anode vector and drives the matching hex
// digit, decimal point and anode onto the display pins. New values arrive
// through a one-deep pending buffer and are applied only at frame
// boundaries, so a value never tears across digits. Each anode change
// blanks all outputs for BLANK_CYCLES clocks. Optional leading-zero
// suppression blanks unused upper digits.
//
// Handshake: value_ready is high while the pending buffer is empty. A
// transfer happens on a clock edge where value_valid and value_ready are
// both high. value/dp_in are sampled on that edge, and value_ready drops
// on the next cycle. It stays low until a frame boundary moves the pending
// value into the display register.
module seven_seg_digit_driver #(
  parameter int BLANK_CYCLES = 4,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  anode_in,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        value_valid,
  output logic        value_ready,
  output logic [3:0]  anode,
  output logic [6:0]  segment,
  output logic        dp
);

  localparam int CW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  logic [3:0]    sync1, sync2, hist;
  logic [CW-1:0] cnt, cnt_next;
  logic          change, boundary, take;
  logic [15:0]   pend, disp, disp_next;
  logic [3:0]    pend_dp, disp_dp, disp_dp_next;
  logic          pend_full;
  logic          legal;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic [3:1]    lz;
  logic [3:0]    anode_next;
  logic [6:0]    segment_next;
  logic          dp_next;

  // Active-low g..a pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  assign change      = (sync2 != hist);
  assign boundary    = (hist == 4'b0111) && (sync2 == 4'b1110);
  assign value_ready = ~pend_full;
  assign take        = value_valid & value_ready;

  // Blank counter: reload on every anode change, otherwise count down to 0.
  always_comb begin
    cnt_next = cnt;
    if (change) begin
      cnt_next = CW'(BLANK_CYCLES);
    end else if (cnt != '0) begin
      cnt_next = cnt - CW'(1);
    end
  end

  // Display contents after this edge: pending moves over only at a boundary.
  always_comb begin
    disp_next    = disp;
    disp_dp_next = disp_dp;
    if (boundary && pend_full) begin
      disp_next    = pend;
      disp_dp_next = pend_dp;
    end
  end

  // Select the digit for the synchronized anode and build the pin values.
  always_comb begin
    legal = 1'b1;
    idx   = 2'd0;
    case (sync2)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: legal = 1'b0;
    endcase
    nib   = disp_next[{idx, 2'b00} +: 4];
    lz[3] = (disp_next[15:12] == 4'h0);
    lz[2] = lz[3] && (disp_next[11:8] == 4'h0);
    lz[1] = lz[2] && (disp_next[7:4] == 4'h0);

    anode_next   = 4'b1111;
    segment_next = 7'b1111111;
    dp_next      = 1'b1;
    if (legal && (cnt_next == '0)) begin
      anode_next = sync2;
      if (LZ_BLANK && (idx != 2'd0) && lz[idx]) begin
        segment_next = 7'b1111111;
      end else begin
        segment_next = hex_to_seg(nib);
      end
      dp_next = ~disp_dp_next[idx];
    end
  end

  // Synchronizer, anode history and blank counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 4'b1111;
      sync2 <= 4'b1111;
      hist  <= 4'b1111;
      cnt   <= '0;
    end else begin
      sync1 <= anode_in;
      sync2 <= sync1;
      hist  <= sync2;
      cnt   <= cnt_next;
    end
  end

  // Pending buffer and display register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend      <= 16'h0000;
      pend_dp   <= 4'b0000;
      pend_full <= 1'b0;
      disp      <= 16'h0000;
      disp_dp   <= 4'b0000;
    end else begin
      disp    <= disp_next;
      disp_dp <= disp_dp_next;
      if (take) begin
        pend      <= value;
        pend_dp   <= dp_in;
        pend_full <= 1'b1;
      end else if (boundary && pend_full) begin
        pend_full <= 1'b0;
      end
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anode   <= 4'b1111;
      segment <= 7'b1111111;
      dp      <= 1'b1;
    end else begin
      anode   <= anode_next;
      segment <= segment_next;
      dp      <= dp_next;
    end
  end

endmodule
